// File: rtl/alert_pkg.sv
// Shared constants and FSM state type for the alert TX packer.
package alert_pkg;
    localparam int REC_W         = 80;
    localparam int BEATS_PER_REC = 2;
    localparam int WORDS_PER_REC = 4;
    localparam logic [15:0] MAGIC = 16'hA1E7;

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} tx_state_e;
endpackage

// File: rtl/alert_fifo.sv
// First-word-fall-through record FIFO with registered occupancy count.
module alert_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alert_tx_packer.sv
// Buffers alert records and uploads them in batches as one RIFFA TX
// transaction, two 64-bit beats per record with a running sequence number.
module alert_tx_packer
    import alert_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int DEPTH            = 16,
    parameter int THRESH           = 8,
    parameter int TIMEOUT          = 1024
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        REC_VALID,
    input  logic [15:0]                 REC_INFO,
    input  logic [63:0]                 REC_DATA,
    output logic                        REC_READY,
    input  logic                        FLUSH,
    output logic [15:0]                 DROP_CNT,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    if (C_PCI_DATA_WIDTH != 64) begin : g_bad_width
        $error("alert_tx_packer: only C_PCI_DATA_WIDTH=64 is supported");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alert_tx_packer: DEPTH must be a power of 2 in 2..256");
    end
    if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
        $error("alert_tx_packer: THRESH must be in 1..DEPTH");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("alert_tx_packer: TIMEOUT must be >= 1");
    end

    tx_state_e       state, state_nxt;
    logic [TW-1:0]   tcnt;
    logic [15:0]     seq;
    logic [CW-1:0]   remain;
    logic            beat;
    logic [31:0]     len_q;
    logic [15:0]     drop_q;

    logic [REC_W-1:0] head;
    logic [CW-1:0]    count;
    logic             full, empty;
    logic             push, pop, accept, last_beat, trigger;

    assign push      = REC_VALID && !full;
    assign accept    = (state == SEND) && CHNL_TX_DATA_REN;
    assign last_beat = (beat == 1'(BEATS_PER_REC - 1));
    assign pop       = accept && last_beat;
    assign trigger   = (state == IDLE) && !empty &&
                       ((count >= CW'(THRESH)) || (tcnt >= TW'(TIMEOUT - 1)) || FLUSH);

    alert_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .din   ({REC_INFO, REC_DATA}),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = REQ;
            REQ:     if (CHNL_TX_ACK) state_nxt = SEND;
            SEND:    if (pop && remain == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // N is frozen at trigger; later pushes wait for the next batch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt   <= '0;
            seq    <= '0;
            remain <= '0;
            beat   <= 1'b0;
            len_q  <= '0;
            drop_q <= '0;
        end else begin
            if (empty || state != IDLE) tcnt <= '0;
            else                        tcnt <= tcnt + 1'b1;

            if (trigger) begin
                remain <= count;
                len_q  <= 32'(count) * 32'(WORDS_PER_REC);
            end else if (pop) begin
                remain <= remain - 1'b1;
            end

            if (state != SEND) beat <= 1'b0;
            else if (accept)   beat <= ~beat;

            if (pop) seq <= seq + 16'd1;

            if (REC_VALID && full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    // Data comes straight off the FWFT head, so it is stable while REN=0.
    always_comb begin
        CHNL_TX_DATA = '0;
        if (state == SEND) begin
            if (beat) CHNL_TX_DATA = head[63:0];
            else      CHNL_TX_DATA = {MAGIC, seq, 16'h0000, head[REC_W-1:64]};
        end
    end

    assign CHNL_TX            = (state == REQ) || (state == SEND);
    assign CHNL_TX_DATA_VALID = (state == SEND);
    assign CHNL_TX_LEN        = len_q;
    assign CHNL_TX_CLK        = CLK;
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = '0;
    assign REC_READY          = !full;
    assign DROP_CNT           = drop_q;
endmodule

// File: tb/tb_alert_tx_packer.sv
// Directed bench for alert_tx_packer: threshold, timeout, backpressure,
// full/drop, flush and mid-transaction reset.
module tb_alert_tx_packer;
    logic        CLK, RST;
    logic        REC_VALID, REC_READY, FLUSH;
    logic [15:0] REC_INFO, DROP_CNT;
    logic [63:0] REC_DATA;
    logic        CHNL_TX_CLK, CHNL_TX, CHNL_TX_ACK, CHNL_TX_LAST;
    logic [31:0] CHNL_TX_LEN;
    logic [30:0] CHNL_TX_OFF;
    logic [63:0] CHNL_TX_DATA;
    logic        CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN;

    alert_tx_packer dut (
        .CLK(CLK), .RST(RST),
        .REC_VALID(REC_VALID), .REC_INFO(REC_INFO), .REC_DATA(REC_DATA),
        .REC_READY(REC_READY), .FLUSH(FLUSH), .DROP_CNT(DROP_CNT),
        .CHNL_TX_CLK(CHNL_TX_CLK), .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK),
        .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
        .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          nvec, nerr;
    logic [15:0] sb_info[$];
    logic [63:0] sb_data[$];
    logic [15:0] exp_seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        sb_info.delete();
        sb_data.delete();
        exp_seq = 16'd0;
        @(negedge CLK);
    endtask

    task automatic push_rec(input logic [15:0] info, input logic [63:0] data, input bit acc);
        REC_VALID = 1'b1;
        REC_INFO  = info;
        REC_DATA  = data;
        if (acc) begin
            sb_info.push_back(info);
            sb_data.push_back(data);
        end
        @(negedge CLK);
        REC_VALID = 1'b0;
    endtask

    task automatic pulse_flush();
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
    endtask

    // ren_mode=1 drives REN 1,0,0,1 repeating; extra=1 pushes two records mid-SEND;
    // stop_after>0 leaves the transaction in SEND after that many beats.
    task automatic do_batch(input int exp_len, input int ack_dly, input bit ren_mode,
                            input bit extra, input int stop_after);
        int          w, n, beats, k;
        logic        ren, hold_pend;
        logic [63:0] prev, expv;
        w = 0;
        while (!CHNL_TX && w < 2000) begin
            @(negedge CLK);
            w++;
        end
        chk("tx_req", 64'(CHNL_TX), 64'd1);
        if (!CHNL_TX) return;
        chk("tx_len", 64'(CHNL_TX_LEN), 64'(exp_len));
        chk("req_valid_low", 64'(CHNL_TX_DATA_VALID), 64'd0);
        repeat (ack_dly) @(negedge CLK);
        CHNL_TX_ACK = 1'b1;
        @(negedge CLK);
        CHNL_TX_ACK = 1'b0;
        n = exp_len / 4;
        beats = 0;
        k = 0;
        hold_pend = 1'b0;
        prev = '0;
        while (beats < 2 * n && k < 400) begin
            REC_VALID = 1'b0;
            if (extra && (k == 2 || k == 4)) begin
                chk("ready_in_send", 64'(REC_READY), 64'd1);
                REC_VALID = 1'b1;
                REC_INFO  = 16'h0200 + 16'(k);
                REC_DATA  = 64'h2000 + 64'(k);
                sb_info.push_back(REC_INFO);
                sb_data.push_back(REC_DATA);
            end
            ren = ren_mode ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            CHNL_TX_DATA_REN = ren;
            if (hold_pend) chk("data_hold", CHNL_TX_DATA, prev);
            if (CHNL_TX_DATA_VALID && ren) begin
                if (beats % 2 == 0) begin
                    expv = {16'hA1E7, exp_seq, 16'h0000, sb_info[0]};
                    chk("beat0", CHNL_TX_DATA, expv);
                end else begin
                    chk("beat1", CHNL_TX_DATA, sb_data[0]);
                    void'(sb_info.pop_front());
                    void'(sb_data.pop_front());
                    exp_seq = exp_seq + 16'd1;
                end
                beats++;
            end
            hold_pend = CHNL_TX_DATA_VALID && !ren;
            prev = CHNL_TX_DATA;
            k++;
            @(negedge CLK);
            if (stop_after > 0 && beats == stop_after) break;
        end
        CHNL_TX_DATA_REN = 1'b0;
        REC_VALID = 1'b0;
        if (stop_after > 0) return;
        chk("beat_count", 64'(beats), 64'(2 * n));
        chk("done_tx_low", 64'(CHNL_TX), 64'd0);
        chk("done_valid_low", 64'(CHNL_TX_DATA_VALID), 64'd0);
    endtask

    initial begin
        int  n;
        bit  saw_tx;
        nvec = 0; nerr = 0;
        RST = 1'b1;
        REC_VALID = 1'b0; REC_INFO = '0; REC_DATA = '0; FLUSH = 1'b0;
        CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b0;
        exp_seq = 16'd0;
        repeat (2) @(negedge CLK);
        chk("rst_ready", 64'(REC_READY), 64'd1);
        chk("rst_tx", 64'(CHNL_TX), 64'd0);
        chk("rst_valid", 64'(CHNL_TX_DATA_VALID), 64'd0);
        chk("rst_len", 64'(CHNL_TX_LEN), 64'd0);
        chk("rst_data", CHNL_TX_DATA, 64'd0);
        chk("rst_drop", 64'(DROP_CNT), 64'd0);
        chk("tx_last", 64'(CHNL_TX_LAST), 64'd1);
        chk("tx_off", 64'(CHNL_TX_OFF), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Threshold: 8 records trigger LEN=32, ACK after 2 cycles.
        for (int i = 0; i < 8; i++) push_rec(16'(i), 64'h1000 + 64'(i), 1'b1);
        do_batch(32, 2, 1'b0, 1'b0, 0);

        // Flush on an empty FIFO is ignored.
        pulse_flush();
        saw_tx = 1'b0;
        repeat (20) begin
            if (CHNL_TX) saw_tx = 1'b1;
            @(negedge CLK);
        end
        chk("flush_empty", 64'(saw_tx), 64'd0);

        // Flush 3 records; sequence continues at 8.
        for (int i = 0; i < 3; i++) push_rec(16'h0100 + 16'(i), 64'h3000 + 64'(i), 1'b1);
        pulse_flush();
        do_batch(12, 1, 1'b0, 1'b0, 0);

        // Timeout: a second push mid-wait does not restart the count.
        do_reset();
        push_rec(16'h00AA, 64'hDEAD_BEEF_0000_0001, 1'b1);
        n = 0;
        while (!CHNL_TX && n < 1100) begin
            REC_VALID = 1'b0;
            if (n == 500) begin
                REC_VALID = 1'b1;
                REC_INFO  = 16'h00BB;
                REC_DATA  = 64'hDEAD_BEEF_0000_0002;
                sb_info.push_back(REC_INFO);
                sb_data.push_back(REC_DATA);
            end
            @(negedge CLK);
            n++;
        end
        REC_VALID = 1'b0;
        chk("timeout_cycles", 64'(n), 64'd1024);
        do_batch(8, 0, 1'b0, 1'b0, 0);

        // Backpressure with REN 1,0,0,1.
        do_reset();
        push_rec(16'h0011, 64'h5555_0000_0000_0011, 1'b1);
        push_rec(16'h0022, 64'h5555_0000_0000_0022, 1'b1);
        pulse_flush();
        do_batch(8, 0, 1'b1, 1'b0, 0);

        // Full/drop: batch of 8 held in REQ while the FIFO fills to 16.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push_rec(16'h0300 + 16'(i), 64'h4000 + 64'(i), i < 16);
            if (i == 14) chk("ready_before_full", 64'(REC_READY), 64'd1);
            if (i == 15) chk("ready_full", 64'(REC_READY), 64'd0);
        end
        chk("drop_cnt", 64'(DROP_CNT), 64'd4);
        do_batch(32, 0, 1'b0, 1'b1, 0);
        do_batch(40, 0, 1'b0, 1'b0, 0);

        // Reset after beat 5 aborts the batch; next batch restarts at SEQ 0.
        do_reset();
        for (int i = 0; i < 4; i++) push_rec(16'h0400 + 16'(i), 64'h6000 + 64'(i), 1'b1);
        pulse_flush();
        do_batch(16, 0, 1'b0, 1'b0, 5);
        RST = 1'b1;
        #1;
        chk("arst_tx", 64'(CHNL_TX), 64'd0);
        chk("arst_valid", 64'(CHNL_TX_DATA_VALID), 64'd0);
        chk("arst_data", CHNL_TX_DATA, 64'd0);
        chk("arst_len", 64'(CHNL_TX_LEN), 64'd0);
        chk("arst_ready", 64'(REC_READY), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        sb_info.delete();
        sb_data.delete();
        exp_seq = 16'd0;
        @(negedge CLK);
        push_rec(16'h0500, 64'h7000, 1'b1);
        pulse_flush();
        do_batch(4, 0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
